// File: rtl/mem_access_stage.sv
// MEM stage: branch/jump redirect, req/ack data-memory access, MEM/WB register; stalls upstream while an access is pending.
// Optional MEM_TIMEOUT_EN aborts an unacknowledged access after TIMEOUT_CYCLES ACCESS cycles.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Branch_in,
  input  logic        Mem_Read_in,
  input  logic        Mem_to_Reg_in,
  input  logic        Mem_Write_in,
  input  logic        Reg_Write_in,
  input  logic        jal_in,
  input  logic        jalr_in,
  input  logic        zero_in,
  input  logic [31:0] RD_in,
  input  logic [31:0] ALU_Result_in,
  input  logic [31:0] B_in,
  input  logic [31:0] immediate_in,
  input  logic [31:0] pc_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        mem_flush,
  output logic        Reg_Write_out,
  output logic        Mem_to_Reg_out,
  output logic [31:0] RD_out,
  output logic [31:0] ALU_Result_out,
  output logic [31:0] Read_Data_out,
  output logic        mem_timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        rw_q, rw_d, mtr_q, mtr_d, tmo_q, tmo_d;
  logic [31:0] rd_q, rd_d, alu_q, alu_d, rdata_q, rdata_d;
  logic        acc, tmo_hit;

  assign acc = Mem_Read_in | Mem_Write_in;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign tmo_hit = (state_q == ACCESS) && !dmem_ack && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign mem_stall = ((state_q == IDLE) && acc) || ((state_q == ACCESS) && !dmem_ack && !tmo_hit);
  assign pc_src    = (Branch_in & zero_in) | jal_in | jalr_in;
  assign mem_flush = pc_src;
  assign pc_target = jalr_in ? (ALU_Result_in & 32'hFFFF_FFFE) : (pc_in + immediate_in);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = 1'b0;
    mtr_d   = 1'b0;
    rd_d    = rd_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    tmo_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = ACCESS;
          req_d   = 1'b1;
          we_d    = Mem_Write_in;
          addr_d  = ALU_Result_in;
          wdata_d = B_in;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else begin
          rw_d  = Reg_Write_in;
          mtr_d = Mem_to_Reg_in;
          rd_d  = RD_in;
          alu_d = (jal_in | jalr_in) ? (pc_in + 32'd4) : ALU_Result_in;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          // Read+Write together is a store, so only a pure read captures data
          if (!Mem_Write_in) rdata_d = dmem_rdata;
          rw_d    = Reg_Write_in;
          mtr_d   = Mem_to_Reg_in;
          rd_d    = RD_in;
          alu_d   = ALU_Result_in;
        end else if (tmo_hit) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          tmo_d   = 1'b1;
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rw_q    <= 1'b0;
      mtr_q   <= 1'b0;
      rd_q    <= 32'd0;
      alu_q   <= 32'd0;
      rdata_q <= 32'd0;
      tmo_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      mtr_q   <= mtr_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign Reg_Write_out  = rw_q;
  assign Mem_to_Reg_out = mtr_q;
  assign RD_out         = rd_q;
  assign ALU_Result_out = alu_q;
  assign Read_Data_out  = rdata_q;
  assign mem_timeout    = tmo_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: redirects, loads/stores with wait states, back-to-back ops, timeout, reset.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Branch_in, Mem_Read_in, Mem_to_Reg_in, Mem_Write_in, Reg_Write_in, jal_in, jalr_in, zero_in;
  logic [31:0] RD_in, ALU_Result_in, B_in, immediate_in, pc_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, pc_src, mem_flush, Reg_Write_out, Mem_to_Reg_out, mem_timeout;
  logic [31:0] pc_target, RD_out, ALU_Result_out, Read_Data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .Branch_in(Branch_in), .Mem_Read_in(Mem_Read_in), .Mem_to_Reg_in(Mem_to_Reg_in),
    .Mem_Write_in(Mem_Write_in), .Reg_Write_in(Reg_Write_in), .jal_in(jal_in), .jalr_in(jalr_in),
    .zero_in(zero_in), .RD_in(RD_in), .ALU_Result_in(ALU_Result_in), .B_in(B_in),
    .immediate_in(immediate_in), .pc_in(pc_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .pc_src(pc_src), .pc_target(pc_target), .mem_flush(mem_flush),
    .Reg_Write_out(Reg_Write_out), .Mem_to_Reg_out(Mem_to_Reg_out), .RD_out(RD_out),
    .ALU_Result_out(ALU_Result_out), .Read_Data_out(Read_Data_out), .mem_timeout(mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Branch_in = 0; Mem_Read_in = 0; Mem_to_Reg_in = 0; Mem_Write_in = 0; Reg_Write_in = 0;
    jal_in = 0; jalr_in = 0; zero_in = 0;
    RD_in = 0; ALU_Result_in = 0; B_in = 0; immediate_in = 0; pc_in = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  initial begin
    clr();
    reset_n = 0;
    tick(); tick();
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_rw", 32'(Reg_Write_out), 32'd0);
    check("rst_alu", ALU_Result_out, 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    reset_n = 1;

    // Branch taken with negative offset
    Branch_in = 1; zero_in = 1; pc_in = 32'h100; immediate_in = 32'hFFFF_FFF8; #1;
    check("br_src", 32'(pc_src), 32'd1);
    check("br_tgt", pc_target, 32'h0000_00F8);
    check("br_flush", 32'(mem_flush), 32'd1);
    zero_in = 0; #1;
    check("br_nt_src", 32'(pc_src), 32'd0);
    tick(); clr();

    // jalr: target LSB cleared, link = pc+4
    jalr_in = 1; ALU_Result_in = 32'h205; pc_in = 32'h100; Reg_Write_in = 1; RD_in = 1; #1;
    check("jalr_tgt", pc_target, 32'h204);
    check("jalr_stall", 32'(mem_stall), 32'd0);
    tick();
    check("jalr_link", ALU_Result_out, 32'h104);
    check("jalr_rw", 32'(Reg_Write_out), 32'd1);
    clr();
    jal_in = 1; pc_in = 32'h200; immediate_in = 32'h10; #1;
    check("jal_tgt", pc_target, 32'h210);
    tick(); clr();
    ALU_Result_in = 32'h77; RD_in = 3; Reg_Write_in = 1;
    tick();
    check("alu_pass", ALU_Result_out, 32'h77);
    check("alu_rd", RD_out, 32'd3);
    clr();

    // Load, acked in third ACCESS cycle
    Mem_Read_in = 1; Mem_to_Reg_in = 1; Reg_Write_in = 1; ALU_Result_in = 32'h40; RD_in = 5; #1;
    check("ld_stall_idle", 32'(mem_stall), 32'd1);
    tick();
    check("ld_bubble", 32'(Reg_Write_out), 32'd0);
    for (int k = 0; k < 2; k++) begin
      check("ld_req", 32'(dmem_req), 32'd1);
      check("ld_addr", dmem_addr, 32'h40);
      check("ld_stall", 32'(mem_stall), 32'd1);
      tick();
    end
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF; #1;
    check("ld_stall_ack", 32'(mem_stall), 32'd0);
    tick();
    check("ld_data", Read_Data_out, 32'hDEAD_BEEF);
    check("ld_rd", RD_out, 32'd5);
    check("ld_rw", 32'(Reg_Write_out), 32'd1);
    check("ld_mtr", 32'(Mem_to_Reg_out), 32'd1);
    check("ld_req_drop", 32'(dmem_req), 32'd0);
    clr();

    // Store, zero wait
    Mem_Write_in = 1; ALU_Result_in = 32'h80; B_in = 32'h1234_5678; #1;
    check("st_stall_idle", 32'(mem_stall), 32'd1);
    tick();
    check("st_we", 32'(dmem_we), 32'd1);
    check("st_wdata", dmem_wdata, 32'h1234_5678);
    check("st_addr", dmem_addr, 32'h80);
    dmem_ack = 1; dmem_rdata = 32'hBAD0_BAD0; #1;
    check("st_stall_ack", 32'(mem_stall), 32'd0);
    tick();
    check("st_we_drop", 32'(dmem_we), 32'd0);
    check("st_rw", 32'(Reg_Write_out), 32'd0);
    check("st_rdata_hold", Read_Data_out, 32'hDEAD_BEEF);
    clr();

    // Back-to-back zero-wait loads; stray ack in IDLE must be ignored
    Mem_Read_in = 1; Reg_Write_in = 1; ALU_Result_in = 32'h100; RD_in = 6;
    tick();
    check("b2b_req1", 32'(dmem_req), 32'd1);
    dmem_ack = 1; dmem_rdata = 32'h1111_1111;
    tick();
    check("b2b_req_gap", 32'(dmem_req), 32'd0);
    check("b2b_data1", Read_Data_out, 32'h1111_1111);
    check("b2b_rd1", RD_out, 32'd6);
    ALU_Result_in = 32'h104; RD_in = 7; dmem_rdata = 32'hBAD1_BAD1;
    tick();
    check("b2b_req2", 32'(dmem_req), 32'd1);
    check("b2b_addr2", dmem_addr, 32'h104);
    check("b2b_idle_ack", Read_Data_out, 32'h1111_1111);
    dmem_rdata = 32'h2222_2222;
    tick();
    check("b2b_data2", Read_Data_out, 32'h2222_2222);
    check("b2b_rd2", RD_out, 32'd7);
    clr();

    // Load never acked
    Mem_Read_in = 1; Reg_Write_in = 1; Mem_to_Reg_in = 1; ALU_Result_in = 32'h200; RD_in = 8;
    tick();
    for (int k = 1; k <= 4; k++) begin
`ifdef MEM_TIMEOUT_EN
      check("to_stall", 32'(mem_stall), (k == 4) ? 32'd0 : 32'd1);
`else
      check("to_stall", 32'(mem_stall), 32'd1);
`endif
      check("to_pulse_early", 32'(mem_timeout), 32'd0);
      if (k < 4) tick();
    end
`ifdef MEM_TIMEOUT_EN
    tick();
    check("to_pulse", 32'(mem_timeout), 32'd1);
    check("to_rw", 32'(Reg_Write_out), 32'd0);
    check("to_req", 32'(dmem_req), 32'd0);
    clr();
    tick();
    check("to_pulse_end", 32'(mem_timeout), 32'd0);
`else
    dmem_ack = 1; dmem_rdata = 32'h3333_3333;
    tick();
    check("hang_ack_data", Read_Data_out, 32'h3333_3333);
    clr();
`endif

    // Reset held two cycles while an access is outstanding
    Mem_Read_in = 1; Reg_Write_in = 1; ALU_Result_in = 32'h300; RD_in = 9;
    tick();
    check("rst2_pre_req", 32'(dmem_req), 32'd1);
    reset_n = 0; clr();
    tick(); tick();
    check("rst2_req", 32'(dmem_req), 32'd0);
    check("rst2_addr", dmem_addr, 32'd0);
    check("rst2_rd", RD_out, 32'd0);
    check("rst2_rdata", Read_Data_out, 32'd0);
    check("rst2_stall", 32'(mem_stall), 32'd0);
    reset_n = 1;
    tick();
    check("rst2_idle_req", 32'(dmem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
